ctrl_fsm: RTL and testbench

Parametrised successor to the opcode decoder. It owns its own instruction sequencer (IDLE/DECODE/EXECUTE/WRITEBACK/DONE) instead of sampling an externally supplied state. It accepts one instruction per valid/ready handshake and drives the ALU and register-file control strobes cycle-accurately. It sits between the IO front end and the ALU/register file, and supports multi-cycle execute and illegal-opcode detection.

---
 rtl/ctrl_fsm_if.sv | 30 +++
 rtl/ctrl_fsm.sv | 181 ++++++++++++++++++
 tb/tb_ctrl_fsm.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_fsm_if.sv
// ctrl_fsm_if: instruction handshake plus the ALU/register-file control
// strobes exchanged between the IO front end (master) and ctrl_fsm (slave).
interface ctrl_fsm_if #(
    parameter int OP_W     = 4,
    parameter int ALU_OP_W = 4
);
    logic                instr_valid;
    logic [OP_W-1:0]     opcode;
    logic                instr_ready;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src;
    logic                reg_write;
    logic                read_en;
    logic                busy;
    logic                done;
    logic                illegal;
    logic [2:0]          state;

    modport master (
        output instr_valid, opcode,
        input  instr_ready, alu_op, alu_src, reg_write, read_en,
               busy, done, illegal, state
    );

    modport slave (
        input  instr_valid, opcode,
        output instr_ready, alu_op, alu_src, reg_write, read_en,
               busy, done, illegal, state
    );
endinterface

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: instruction sequencer IDLE -> DECODE -> EXECUTE -> WRITEBACK -> DONE.
// Accepts one opcode per valid/ready handshake, drives registered (Moore)
// ALU and register-file strobes, supports a multi-cycle EXECUTE and flags
// illegal opcodes (>= 16) with a pulse coincident with done.
// Optional macro CTRL_RETIRE_CNT_EN adds retire_cnt (wrapping) and
// illegal_cnt (saturating) counters.
module ctrl_fsm #(
    parameter int OP_W        = 4,
    parameter int ALU_OP_W    = 4,
    parameter int EXEC_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    ctrl_fsm_if.slave  bus
`ifdef CTRL_RETIRE_CNT_EN
    ,
    output logic [15:0] retire_cnt,
    output logic [7:0]  illegal_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'b000,
        S_DECODE    = 3'b001,
        S_EXECUTE   = 3'b010,
        S_WRITEBACK = 3'b011,
        S_DONE      = 3'b100
    } state_e;

    // Decoded view of a latched opcode.
    typedef struct packed {
        logic illegal;
        logic nop;
        logic read;
        logic write;
        logic src_imm;
    } op_class_t;

    function automatic op_class_t classify(input logic [OP_W-1:0] op);
        op_class_t c;
        logic [3:0] nib;
        nib       = op[3:0];
        c.illegal = (op >> 4) != '0;
        c.nop     = !c.illegal && (nib == 4'd0);
        c.read    = !c.illegal && (nib == 4'd2);
        c.write   = !c.illegal && (nib != 4'd0) && (nib != 4'd2);
        c.src_imm = !c.illegal && ((nib == 4'd1) || (nib >= 4'd12));
        return c;
    endfunction

    state_e              state_q, state_d;
    logic [OP_W-1:0]     opcode_q, opcode_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                instr_ready_q, instr_ready_d;
    logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
    logic                alu_src_q, alu_src_d;
    logic                reg_write_q, reg_write_d;
    logic                read_en_q, read_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                illegal_q, illegal_d;
    op_class_t           cls_q, cls_d;

    assign cls_q = classify(opcode_q);
    assign cls_d = classify(opcode_d);

    // Next state, latched opcode, execute counter and the Moore outputs of the next state.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d       = state_q;
        opcode_d      = opcode_q;
        cnt_d         = cnt_q;
        instr_ready_d = 1'b0;
        alu_op_d      = '0;
        alu_src_d     = 1'b0;
        reg_write_d   = 1'b0;
        read_en_d     = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        illegal_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.instr_valid && instr_ready_q) begin
                    opcode_d = bus.opcode;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (cls_q.nop || cls_q.illegal) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = 4'(EXEC_CYCLES - 1);
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (cnt_q == 4'd0) state_d = S_WRITEBACK;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_WRITEBACK: state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase

        // Outputs are computed for the state being entered, so they are registered.
        instr_ready_d = (state_d == S_IDLE);
        busy_d        = (state_d == S_DECODE) || (state_d == S_EXECUTE) ||
                        (state_d == S_WRITEBACK);
        if ((state_d == S_EXECUTE) || (state_d == S_WRITEBACK)) begin
            alu_op_d  = ALU_OP_W'(opcode_d[3:0]);
            alu_src_d = cls_d.src_imm;
        end
        reg_write_d = (state_d == S_WRITEBACK) && cls_d.write;
        read_en_d   = (state_d == S_WRITEBACK) && cls_d.read;
        done_d      = (state_d == S_DONE);
        illegal_d   = (state_d == S_DONE) && cls_d.illegal;
    end

    // Sequencer state and registered outputs; reset returns to IDLE immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            opcode_q      <= '0;
            cnt_q         <= '0;
            instr_ready_q <= 1'b1;
            alu_op_q      <= '0;
            alu_src_q     <= 1'b0;
            reg_write_q   <= 1'b0;
            read_en_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values together.
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            cnt_q         <= cnt_d;
            instr_ready_q <= instr_ready_d;
            alu_op_q      <= alu_op_d;
            alu_src_q     <= alu_src_d;
            reg_write_q   <= reg_write_d;
            read_en_q     <= read_en_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            illegal_q     <= illegal_d;
        end
    end

`ifdef CTRL_RETIRE_CNT_EN
    logic [15:0] retire_cnt_q;
    logic [7:0]  illegal_cnt_q;

    // Counters advance on the same edge that raises done/illegal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt_q  <= '0;
            illegal_cnt_q <= '0;
        end else begin
            if (done_d)
                retire_cnt_q <= retire_cnt_q + 16'd1;
            if (illegal_d && (illegal_cnt_q != 8'hFF))
                illegal_cnt_q <= illegal_cnt_q + 8'd1;
        end
    end

    assign retire_cnt  = retire_cnt_q;
    assign illegal_cnt = illegal_cnt_q;
`endif

    assign bus.instr_ready = instr_ready_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_src     = alu_src_q;
    assign bus.reg_write   = reg_write_q;
    assign bus.read_en     = read_en_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.illegal     = illegal_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: directed bench for ctrl_fsm. Three instances cover
// EXEC_CYCLES=1 (u_d1), EXEC_CYCLES=3 (u_d3) and OP_W=5 (u_d5).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ctrl_fsm;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    ctrl_fsm_if #(.OP_W(4), .ALU_OP_W(4)) if1 ();
    ctrl_fsm_if #(.OP_W(4), .ALU_OP_W(4)) if3 ();
    ctrl_fsm_if #(.OP_W(5), .ALU_OP_W(4)) if5 ();

`ifdef CTRL_RETIRE_CNT_EN
    logic [15:0] rc1, rc3, rc5;
    logic [7:0]  ic1, ic3, ic5;
`endif

    ctrl_fsm #(.OP_W(4), .ALU_OP_W(4), .EXEC_CYCLES(1)) u_d1 (
        .clk(clk), .rst(rst), .bus(if1)
`ifdef CTRL_RETIRE_CNT_EN
        , .retire_cnt(rc1), .illegal_cnt(ic1)
`endif
    );
    ctrl_fsm #(.OP_W(4), .ALU_OP_W(4), .EXEC_CYCLES(3)) u_d3 (
        .clk(clk), .rst(rst), .bus(if3)
`ifdef CTRL_RETIRE_CNT_EN
        , .retire_cnt(rc3), .illegal_cnt(ic3)
`endif
    );
    ctrl_fsm #(.OP_W(5), .ALU_OP_W(4), .EXEC_CYCLES(1)) u_d5 (
        .clk(clk), .rst(rst), .bus(if5)
`ifdef CTRL_RETIRE_CNT_EN
        , .retire_cnt(rc5), .illegal_cnt(ic5)
`endif
    );

    // Packed output vector: {state, alu_op, alu_src, reg_write, read_en, busy, done, illegal, instr_ready}
    function automatic logic [15:0] pk(input logic [2:0] st, input logic [3:0] alu,
                                       input logic src, input logic rw, input logic rd,
                                       input logic bz, input logic dn, input logic il,
                                       input logic rdy);
        return {2'b00, st, alu, src, rw, rd, bz, dn, il, rdy};
    endfunction

    function automatic logic [15:0] obs1();
        return pk(if1.state, if1.alu_op, if1.alu_src, if1.reg_write, if1.read_en,
                  if1.busy, if1.done, if1.illegal, if1.instr_ready);
    endfunction
    function automatic logic [15:0] obs3();
        return pk(if3.state, if3.alu_op, if3.alu_src, if3.reg_write, if3.read_en,
                  if3.busy, if3.done, if3.illegal, if3.instr_ready);
    endfunction
    function automatic logic [15:0] obs5();
        return pk(if5.state, if5.alu_op, if5.alu_src, if5.reg_write, if5.read_en,
                  if5.busy, if5.done, if5.illegal, if5.instr_ready);
    endfunction

    logic [15:0] idle_v;
    logic [15:0] got;

    task automatic test_reset();
        logic [15:0] exp_v [3];
        rst = 1'b1;
        repeat (2) @(negedge clk);
        exp_v[0] = obs1(); exp_v[1] = obs3(); exp_v[2] = obs5();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (exp_v[i] !== idle_v) $display("FAIL reset_state dut%0d: got %h expected %h", i, exp_v[i], idle_v);
            else passed++;
        end
`ifdef CTRL_RETIRE_CNT_EN
        checks++;
        if ({rc1, ic1, rc5, ic5} !== 48'h0) $display("FAIL reset_counters: got %h expected 0", {rc1, ic1, rc5, ic5});
        else passed++;
`endif
        rst = 1'b0;
        // Accept ADD, then reset in the middle of EXECUTE.
        if1.instr_valid = 1'b1; if1.opcode = 4'd10;
        @(negedge clk);
        if1.instr_valid = 1'b0;
        @(negedge clk);
        got = obs1();
        checks++;
        if (got !== pk(3'd2, 4'd10, 0, 0, 0, 1, 0, 0, 0)) $display("FAIL reset_pre_exec: got %h expected %h", got, pk(3'd2, 4'd10, 0, 0, 0, 1, 0, 0, 0));
        else passed++;
        rst = 1'b1;
        #1;
        got = obs1();
        checks++;
        if (got !== idle_v) $display("FAIL reset_async: got %h expected %h", got, idle_v);
        else passed++;
        @(negedge clk);
        got = obs1();
        checks++;
        if (got !== idle_v) $display("FAIL reset_held: got %h expected %h", got, idle_v);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        got = obs1();
        checks++;
        if (got !== idle_v) $display("FAIL reset_release: got %h expected %h", got, idle_v);
        else passed++;
    endtask

    task automatic test_add();
        logic [15:0] exp_v [5];
        exp_v[0] = pk(3'd1, 4'd0,  0, 0, 0, 1, 0, 0, 0);
        exp_v[1] = pk(3'd2, 4'd10, 0, 0, 0, 1, 0, 0, 0);
        exp_v[2] = pk(3'd3, 4'd10, 0, 1, 0, 1, 0, 0, 0);
        exp_v[3] = pk(3'd4, 4'd0,  0, 0, 0, 0, 1, 0, 0);
        exp_v[4] = idle_v;
        if1.instr_valid = 1'b1; if1.opcode = 4'd10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            got = obs1();
            checks++;
            if (got !== exp_v[i]) $display("FAIL add c%0d: got %h expected %h", i + 1, got, exp_v[i]);
            else passed++;
            if1.instr_valid = 1'b0;
        end
    endtask

    task automatic test_multicycle();
        logic [15:0] exp_v [7];
        exp_v[0] = pk(3'd1, 4'd0,  0, 0, 0, 1, 0, 0, 0);
        exp_v[1] = pk(3'd2, 4'd12, 1, 0, 0, 1, 0, 0, 0);
        exp_v[2] = pk(3'd2, 4'd12, 1, 0, 0, 1, 0, 0, 0);
        exp_v[3] = pk(3'd2, 4'd12, 1, 0, 0, 1, 0, 0, 0);
        exp_v[4] = pk(3'd3, 4'd12, 1, 1, 0, 1, 0, 0, 0);
        exp_v[5] = pk(3'd4, 4'd0,  0, 0, 0, 0, 1, 0, 0);
        exp_v[6] = idle_v;
        if3.instr_valid = 1'b1; if3.opcode = 4'd12;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            got = obs3();
            checks++;
            if (got !== exp_v[i]) $display("FAIL addi_exec3 c%0d: got %h expected %h", i + 1, got, exp_v[i]);
            else passed++;
            if3.instr_valid = 1'b0;
        end
    endtask

    task automatic test_read_nop();
        logic [15:0] exp_v [8];
        // Read: five cycles, then NOP accepted in the IDLE cycle: three cycles.
        exp_v[0] = pk(3'd1, 4'd0, 0, 0, 0, 1, 0, 0, 0);
        exp_v[1] = pk(3'd2, 4'd2, 0, 0, 0, 1, 0, 0, 0);
        exp_v[2] = pk(3'd3, 4'd2, 0, 0, 1, 1, 0, 0, 0);
        exp_v[3] = pk(3'd4, 4'd0, 0, 0, 0, 0, 1, 0, 0);
        exp_v[4] = idle_v;
        exp_v[5] = pk(3'd1, 4'd0, 0, 0, 0, 1, 0, 0, 0);
        exp_v[6] = pk(3'd4, 4'd0, 0, 0, 0, 0, 1, 0, 0);
        exp_v[7] = idle_v;
        if1.instr_valid = 1'b1; if1.opcode = 4'd2;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            got = obs1();
            checks++;
            if (got !== exp_v[i]) $display("FAIL read_nop c%0d: got %h expected %h", i + 1, got, exp_v[i]);
            else passed++;
            if (i == 4) begin
                if1.instr_valid = 1'b1; if1.opcode = 4'd0;
            end else begin
                if1.instr_valid = 1'b0;
            end
        end
    endtask

    task automatic test_illegal();
        logic [15:0] exp_v [3];
        exp_v[0] = pk(3'd1, 4'd0, 0, 0, 0, 1, 0, 0, 0);
        exp_v[1] = pk(3'd4, 4'd0, 0, 0, 0, 0, 1, 1, 0);
        exp_v[2] = idle_v;
        if5.instr_valid = 1'b1; if5.opcode = 5'd17;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = obs5();
            checks++;
            if (got !== exp_v[i]) $display("FAIL illegal c%0d: got %h expected %h", i + 1, got, exp_v[i]);
            else passed++;
            if5.instr_valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_v [11];
        logic [3:0]  next_op [11];
        // AND executes; opcode churn while busy is ignored; NOR accepted in the first IDLE cycle.
        exp_v[0]  = pk(3'd1, 4'd0, 0, 0, 0, 1, 0, 0, 0);
        exp_v[1]  = pk(3'd2, 4'd5, 0, 0, 0, 1, 0, 0, 0);
        exp_v[2]  = pk(3'd3, 4'd5, 0, 1, 0, 1, 0, 0, 0);
        exp_v[3]  = pk(3'd4, 4'd0, 0, 0, 0, 0, 1, 0, 0);
        exp_v[4]  = idle_v;
        exp_v[5]  = pk(3'd1, 4'd0, 0, 0, 0, 1, 0, 0, 0);
        exp_v[6]  = pk(3'd2, 4'd9, 0, 0, 0, 1, 0, 0, 0);
        exp_v[7]  = pk(3'd3, 4'd9, 0, 1, 0, 1, 0, 0, 0);
        exp_v[8]  = pk(3'd4, 4'd0, 0, 0, 0, 0, 1, 0, 0);
        exp_v[9]  = idle_v;
        exp_v[10] = idle_v;
        next_op[0] = 4'd6;  next_op[1] = 4'd7;  next_op[2] = 4'd3;  next_op[3] = 4'd8;
        next_op[4] = 4'd9;  next_op[5] = 4'd11; next_op[6] = 4'd12; next_op[7] = 4'd15;
        next_op[8] = 4'd1;  next_op[9] = 4'd1;  next_op[10] = 4'd1;
        if1.instr_valid = 1'b1; if1.opcode = 4'd5;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            got = obs1();
            checks++;
            if (got !== exp_v[i]) $display("FAIL back_to_back c%0d: got %h expected %h", i + 1, got, exp_v[i]);
            else passed++;
            if1.opcode = next_op[i];
            if (i >= 7) if1.instr_valid = 1'b0;
        end
    endtask

    task automatic test_counters();
`ifdef CTRL_RETIRE_CNT_EN
        // u_d1 retired ADD, Read, NOP, AND, NOR after the last reset; u_d5 one illegal.
        checks++;
        if (rc1 !== 16'd5) $display("FAIL retire_cnt_d1: got %0d expected 5", rc1);
        else passed++;
        checks++;
        if (ic1 !== 8'd0) $display("FAIL illegal_cnt_d1: got %0d expected 0", ic1);
        else passed++;
        checks++;
        if (rc3 !== 16'd1) $display("FAIL retire_cnt_d3: got %0d expected 1", rc3);
        else passed++;
        checks++;
        if (rc5 !== 16'd1) $display("FAIL retire_cnt_d5: got %0d expected 1", rc5);
        else passed++;
        checks++;
        if (ic5 !== 8'd1) $display("FAIL illegal_cnt_d5: got %0d expected 1", ic5);
        else passed++;
        checks++;
        if (ic3 !== 8'd0) $display("FAIL illegal_cnt_d3: got %0d expected 0", ic3);
        else passed++;
`endif
    endtask

    initial begin
        idle_v = pk(3'd0, 4'd0, 0, 0, 0, 0, 0, 0, 1);
        rst = 1'b1;
        if1.instr_valid = 1'b0; if1.opcode = '0;
        if3.instr_valid = 1'b0; if3.opcode = '0;
        if5.instr_valid = 1'b0; if5.opcode = '0;
        test_reset();
        test_add();
        test_multicycle();
        test_read_nop();
        test_illegal();
        test_back_to_back();
        test_counters();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
